// File: rtl/vc_fifo_bank_pkg.sv
// Shared constants and types for the multi-channel TC/VC FIFO bank.
package vc_fifo_bank_pkg;

    localparam int unsigned DEF_BW    = 6;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_NCH   = 4;

    // Ceiling log2 for parameter derivation; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } chan_flags_t;

endpackage

// File: rtl/vc_fifo_chan.sv
// One FIFO channel: storage, wrapping pointers, fill counter and sticky errors.
module vc_fifo_chan
    import vc_fifo_bank_pkg::*;
#(
    parameter  int unsigned BW    = DEF_BW,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned FW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          wr_acc,
    input  logic          rd_acc,
    input  logic          set_ovr,
    input  logic          set_udr,
    input  logic          err_clr,
    input  logic [BW-1:0] din,
    input  logic [FW-1:0] umbral_bajo,
    input  logic [FW-1:0] umbral_alto,
    output logic [BW-1:0] head_c,
    output chan_flags_t   flags_c,
    output logic [FW-1:0] fill,
    output logic          err_c
);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wraddr;
    logic [AW-1:0] rdaddr;
    logic          ovr;
    logic          udr;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage has no reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (reset_L && wr_acc) mem[wraddr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wraddr <= '0;
            rdaddr <= '0;
            fill   <= '0;
            ovr    <= 1'b0;
            udr    <= 1'b0;
        end else begin
            if (wr_acc) wraddr <= next_ptr(wraddr);
            if (rd_acc) rdaddr <= next_ptr(rdaddr);
            case ({wr_acc, rd_acc})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
            // A new error event wins over a same-cycle clear.
            ovr <= set_ovr | (ovr & ~err_clr);
            udr <= set_udr | (udr & ~err_clr);
        end
    end

    assign head_c  = mem[rdaddr];
    assign err_c   = ovr | udr;
    assign flags_c = '{
        full:         (fill == FW'(DEPTH)),
        empty:        (fill == '0),
        almost_full:  (fill >= umbral_alto),
        almost_empty: (fill <= umbral_bajo)
    };

endmodule

// File: rtl/vc_fifo_bank.sv
// NCH independent FIFOs behind one write port and one read port, selected by channel index.
module vc_fifo_bank
    import vc_fifo_bank_pkg::*;
#(
    parameter  int unsigned BW      = DEF_BW,
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    parameter  int unsigned NCH     = DEF_NCH,
    parameter  int unsigned REG_OUT = 0,
    localparam int unsigned FW      = clog2(DEPTH) + 1,
    localparam int unsigned CW      = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              fifo_wr,
    input  logic [CW-1:0]     fifo_wr_ch,
    input  logic [BW-1:0]     fifo_data_in,
    input  logic              fifo_rd,
    input  logic [CW-1:0]     fifo_rd_ch,
    input  logic [FW-1:0]     umbral_bajo,
    input  logic [FW-1:0]     umbral_alto,
    input  logic [NCH-1:0]    err_clr,
    output logic [BW-1:0]     fifo_data_out,
    output logic              fifo_rd_valid,
    output logic [NCH-1:0]    fifo_full,
    output logic [NCH-1:0]    fifo_empty,
    output logic [NCH-1:0]    fifo_almost_full,
    output logic [NCH-1:0]    fifo_almost_empty,
    output logic [NCH*FW-1:0] fifo_fill,
    output logic [NCH-1:0]    error_output
);

    logic [NCH-1:0] wr_req;
    logic [NCH-1:0] rd_req;
    logic [NCH-1:0] wr_acc;
    logic [NCH-1:0] rd_acc;
    logic [BW-1:0]  head_c  [NCH];
    chan_flags_t    flags_c [NCH];
    logic [FW-1:0]  fill    [NCH];
    logic [BW-1:0]  rd_data_c;
    logic           rd_valid_c;

    // Channel decode; out-of-range indices match no channel, and reset blocks all requests.
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign wr_req[c] = reset_L && fifo_wr && (fifo_wr_ch == CW'(c));
        assign rd_req[c] = reset_L && fifo_rd && (fifo_rd_ch == CW'(c));
        assign rd_acc[c] = rd_req[c] && !flags_c[c].empty;
        assign wr_acc[c] = wr_req[c] && (!flags_c[c].full || rd_acc[c]);

        vc_fifo_chan #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk         (clk),
            .reset_L     (reset_L),
            .wr_acc      (wr_acc[c]),
            .rd_acc      (rd_acc[c]),
            .set_ovr     (wr_req[c] && !wr_acc[c]),
            .set_udr     (rd_req[c] && !rd_acc[c]),
            .err_clr     (err_clr[c]),
            .din         (fifo_data_in),
            .umbral_bajo (umbral_bajo),
            .umbral_alto (umbral_alto),
            .head_c      (head_c[c]),
            .flags_c     (flags_c[c]),
            .fill        (fill[c]),
            .err_c       (error_output[c])
        );

        assign fifo_full[c]              = flags_c[c].full;
        assign fifo_empty[c]             = flags_c[c].empty;
        assign fifo_almost_full[c]       = flags_c[c].almost_full;
        assign fifo_almost_empty[c]      = flags_c[c].almost_empty;
        assign fifo_fill[c*FW +: FW]     = fill[c];
    end

    // At most one channel accepts a read, so an OR-mux yields zero when nothing pops.
    always_comb begin
        rd_data_c  = '0;
        rd_valid_c = |rd_acc;
        for (int c = 0; c < NCH; c++) begin
            if (rd_acc[c]) rd_data_c = rd_data_c | head_c[c];
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [BW-1:0] dout_q;
        logic          valid_q;

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= rd_data_c;
                valid_q <= rd_valid_c;
            end
        end

        assign fifo_data_out = dout_q;
        assign fifo_rd_valid = valid_q;
    end else begin : g_comb_out
        assign fifo_data_out = rd_data_c;
        assign fifo_rd_valid = rd_valid_c;
    end

endmodule

// File: doc/vc_fifo_bank.md
# vc_fifo_bank

Multi-channel FIFO bank for the TC/VC datapath: NCH independent FIFOs of DEPTH × BW behind one write port and one read port, each selected by channel index. It generalises the single 16-entry FIFO with:
- arbitrary depth and channel count;
- threshold-range (not equality) almost-flags;
- sticky, clearable per-channel errors;
- an optional registered read path.

It sits between the TC-to-VC mapper (writer) and the VC arbiter (reader).

## Interface
- BW, 6, data width in bits.
- DEPTH, 16, entries per channel, ≥2; need not be a power of two.
- NCH, 4, number of channels, ≥1.
- REG_OUT, 0, read mode: 0 = combinational read data, 1 = registered read data.
- Derived, local only: AW = clog2(DEPTH); FW = AW+1 (fill width, holds 0..DEPTH); CW = max(1, clog2(NCH)).
- clk  in  1  clock; one clock for the whole block.
- reset_L  in  1  reset: synchronous, active-low.
- fifo_wr  in  1  write request.
- fifo_wr_ch  in  CW  write channel index.
- fifo_data_in  in  BW  write data.
- fifo_rd  in  1  read request.
- fifo_rd_ch  in  CW  read channel index.
- umbral_bajo  in  FW  almost-empty threshold, shared by all channels.
- umbral_alto  in  FW  almost-full threshold, shared by all channels.
- err_clr  in  NCH  per-channel error clear pulse.
- fifo_data_out  out  BW  read data.
- fifo_rd_valid  out  1  fifo_data_out carries a popped word.
- fifo_full  out  NCH  per channel: fill == DEPTH.
- fifo_empty  out  NCH  per channel: fill == 0.
- fifo_almost_full  out  NCH  per channel: fill ≥ umbral_alto.
- fifo_almost_empty  out  NCH  per channel: fill ≤ umbral_bajo.
- fifo_fill  out  NCH*FW  per-channel fill counts; channel c occupies bits [c*FW +: FW].
- error_output  out  NCH  per channel: overrun | underrun (sticky).

## Operation
- Per-channel state: wraddr, rdaddr (AW bits each), fill (FW bits), sticky overrun bit, sticky underrun bit.
- Write accepted on channel c when fifo_wr && fifo_wr_ch==c && (!full[c] || read accepted on c in the same cycle).
  - Accepted write: mem[c][wraddr] <= fifo_data_in; wraddr advances.
  - Memory is written only on accepted writes; a full channel's contents are never corrupted.
- Read accepted on channel c when fifo_rd && fifo_rd_ch==c && !empty[c]; rdaddr advances.
- Pointer wrap: a pointer at DEPTH-1 returns to 0; no modulo-2^AW arithmetic.
- Fill per channel: +1 on write only, −1 on read only, unchanged on read+write on the same channel.
- Rejected write (full, no same-cycle read on that channel) sets overrun[c]. Rejected read (empty) sets underrun[c].
  - An empty channel receiving read+write in the same cycle: write accepted, read rejected, underrun set, fill +1.
- Error bits stay set until err_clr[c]. If set and clear occur in the same cycle, set wins.
- Channel index ≥ NCH: request ignored, no state change, no error, read data 0, valid 0.
- Operations on different channels in the same cycle are fully independent.

## Timing
- Reset (reset_L low at a clk edge), all channels: pointers 0, fill 0, errors 0, fifo_data_out 0, fifo_rd_valid 0.
  - Resulting flags: fifo_empty all 1, fifo_full all 0, fifo_almost_empty all 1.
  - fifo_almost_full = (umbral_alto == 0).
  - Reset mid-operation discards all contents; it overrides any same-cycle read or write.
- REG_OUT=0: fifo_data_out = mem[rd_ch][rdaddr] and fifo_rd_valid = 1 in the same cycle as an accepted read; otherwise data 0 and valid 0.
- REG_OUT=1: the popped word and fifo_rd_valid=1 appear one cycle after the accepted read. Otherwise valid is 0 and data holds 0.
- All flags, fill and error bits are registered-state derived. They reflect the post-edge state: a write at edge N makes empty fall at N.
- Back-to-back reads/writes at full rate on any channel.

## Structure
- Shared package/header constants: clog2 function; default BW/DEPTH/NCH.
- Sub-module vc_fifo_chan: one channel's memory, pointers, fill counter and errors.
  - Inputs: accepted-request qualifiers, err_clr.
  - Outputs: head word, flags, fill.
- The top instantiates NCH vc_fifo_chan instances via generate and adds channel decode, the read mux, and the REG_OUT stage.

## Test plan
Defaults BW=6, DEPTH=16, NCH=4 unless stated.
- Write 16 words 0x01..0x10 to ch2, then a 17th word 0x3F → fifo_full[2]=1, error_output[2]=1, fill 16. Read 16 from ch2 → 0x01..0x10 in order (0x3F never appears), then fifo_empty[2]=1.
- Thresholds umbral_alto=12, umbral_bajo=3; fill ch0 from 0 to 16 → almost_empty high for fill 0..3, almost_full high for fill 12..16. Other channels' flags unchanged.
- Empty ch1, read+write 0x15 in the same cycle → underrun on ch1, fill=1; the next read returns 0x15. Full ch1, read+write in the same cycle → fill stays 16, no overrun.
- Pulse err_clr[1] in the same cycle as a new underrun on ch1 → error_output[1] remains 1. A lone err_clr[1] → error_output[1]=0.
- DEPTH=5, NCH=3: 12 interleaved write/read pairs on ch0 → pointers wrap at 4, data order intact. A write with fifo_wr_ch=3 → no state change.
- REG_OUT=1: read ch3 holding 0x2A → fifo_data_out=0x2A, fifo_rd_valid=1 exactly one cycle later. Assert reset with 3 words queued → all fills 0 and valid 0 next cycle.
